vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 242 ++++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: maps a pixel coordinate to an RGB colour one cycle later.
// Modes are latched at frame start; a bouncing square and a frame counter animate some patterns.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned COLOR_BITS  = 4,
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 9,
  parameter int unsigned SQ_SIZE     = 32,
  parameter int unsigned SQ_STEP     = 1,
  parameter int unsigned FRAME_DIV   = 1,
  parameter int unsigned CHECK_SHIFT = 4,
  parameter int unsigned GRAD_SHIFT  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [X_W-1:0]            i_pixel_x,
  input  logic [Y_W-1:0]            i_pixel_y,
  input  logic                      i_de,
  input  logic                      i_frame_start,
  input  logic [2:0]                i_mode,
  output logic [3*COLOR_BITS-1:0]   o_pixel_data,
  output logic                      o_de,
  output logic [2:0]                o_mode
);

  typedef enum logic [2:0] {
    ModeBars,
    ModeChecker,
    ModeGradient,
    ModeSquare,
    ModeGrey,
    ModeGrid,
    ModeBorder,
    ModeFlat
  } mode_e;

  // One extra bit on coordinate arithmetic so sums never wrap.
  localparam int unsigned XCmpW  = X_W + 1;
  localparam int unsigned YCmpW  = Y_W + 1;
  localparam int unsigned SqXMax = H_ACTIVE - SQ_SIZE;
  localparam int unsigned SqYMax = V_ACTIVE - SQ_SIZE;
  localparam int unsigned DivW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(FRAME_DIV - 1);
  localparam logic [COLOR_BITS-1:0] ChOn = '1;

  mode_e                   mode_q, mode_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic [DivW-1:0]         div_cnt_q, div_cnt_d;
  logic [X_W-1:0]          sq_x_q, sq_x_d;
  logic [Y_W-1:0]          sq_y_q, sq_y_d;
  logic                    dir_x_neg_q, dir_x_neg_d;
  logic                    dir_y_neg_q, dir_y_neg_d;
  logic [3*COLOR_BITS-1:0] pix_q, pix_d;
  logic                    de_q;
  logic                    sq_update;

  // Frame-rate state: mode latch, frame counter and square-update divider.
  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    div_cnt_d   = div_cnt_q;
    sq_update   = 1'b0;
    if (i_frame_start) begin
      mode_d      = mode_e'(i_mode);
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (div_cnt_q == DivLast) begin
        div_cnt_d = '0;
        sq_update = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DivW'(1);
      end
    end
  end

  logic [XCmpW-1:0] sq_x_wide, sq_x_inc, sq_x_dec;
  logic [YCmpW-1:0] sq_y_wide, sq_y_inc, sq_y_dec;

  // Bounce: clamp to the edge and reverse when the next step would reach or cross it.
  always_comb begin
    sq_x_wide   = XCmpW'(sq_x_q);
    sq_x_inc    = sq_x_wide + XCmpW'(SQ_STEP);
    sq_x_dec    = sq_x_wide - XCmpW'(SQ_STEP);
    sq_y_wide   = YCmpW'(sq_y_q);
    sq_y_inc    = sq_y_wide + YCmpW'(SQ_STEP);
    sq_y_dec    = sq_y_wide - YCmpW'(SQ_STEP);
    sq_x_d      = sq_x_q;
    sq_y_d      = sq_y_q;
    dir_x_neg_d = dir_x_neg_q;
    dir_y_neg_d = dir_y_neg_q;
    if (sq_update) begin
      if (!dir_x_neg_q) begin
        if (sq_x_inc >= XCmpW'(SqXMax)) begin
          sq_x_d      = X_W'(SqXMax);
          dir_x_neg_d = 1'b1;
        end else begin
          sq_x_d = sq_x_inc[X_W-1:0];
        end
      end else begin
        if (sq_x_wide <= XCmpW'(SQ_STEP)) begin
          sq_x_d      = '0;
          dir_x_neg_d = 1'b0;
        end else begin
          sq_x_d = sq_x_dec[X_W-1:0];
        end
      end
      if (!dir_y_neg_q) begin
        if (sq_y_inc >= YCmpW'(SqYMax)) begin
          sq_y_d      = Y_W'(SqYMax);
          dir_y_neg_d = 1'b1;
        end else begin
          sq_y_d = sq_y_inc[Y_W-1:0];
        end
      end else begin
        if (sq_y_wide <= YCmpW'(SQ_STEP)) begin
          sq_y_d      = '0;
          dir_y_neg_d = 1'b0;
        end else begin
          sq_y_d = sq_y_dec[Y_W-1:0];
        end
      end
    end
  end

  logic [XCmpW-1:0]      x_wide;
  logic [YCmpW-1:0]      y_wide;
  logic                  in_range;
  logic                  in_square;
  logic [2:0]            bar;
  logic [COLOR_BITS-1:0] fc_r, fc_g, fc_b;
  logic [COLOR_BITS-1:0] r, g, b;

  always_comb begin
    x_wide    = XCmpW'(i_pixel_x);
    y_wide    = YCmpW'(i_pixel_y);
    in_range  = (x_wide < XCmpW'(H_ACTIVE)) && (y_wide < YCmpW'(V_ACTIVE));
    in_square = (x_wide >= XCmpW'(sq_x_q)) && (x_wide < XCmpW'(sq_x_q) + XCmpW'(SQ_SIZE)) &&
                (y_wide >= YCmpW'(sq_y_q)) && (y_wide < YCmpW'(sq_y_q) + YCmpW'(SQ_SIZE));
    bar = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (x_wide >= XCmpW'(k * H_ACTIVE / 8)) begin
        bar = 3'(k);
      end
    end
    // Frame-counter fields left-aligned into each channel.
    fc_r = COLOR_BITS'(frame_cnt_q[7:5]) << (COLOR_BITS - 3);
    fc_g = COLOR_BITS'(frame_cnt_q[4:2]) << (COLOR_BITS - 3);
    fc_b = COLOR_BITS'(frame_cnt_q[1:0]) << (COLOR_BITS - 2);
  end

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    if (i_de && in_range) begin
      unique case (mode_q)
        ModeBars: begin
          // Bar order white..black maps bar index bits to inverted G/R/B.
          r = {COLOR_BITS{~bar[1]}};
          g = {COLOR_BITS{~bar[2]}};
          b = {COLOR_BITS{~bar[0]}};
        end
        ModeChecker: begin
          if (i_pixel_x[CHECK_SHIFT] ^ i_pixel_y[CHECK_SHIFT]) begin
            r = ChOn;
            g = ChOn;
            b = ChOn;
          end
        end
        ModeGradient: begin
          r = i_pixel_x[GRAD_SHIFT+COLOR_BITS-1:GRAD_SHIFT];
          g = i_pixel_y[GRAD_SHIFT+COLOR_BITS-1:GRAD_SHIFT];
          b = ChOn;
        end
        ModeSquare: begin
          if (in_square) begin
            r = ChOn;
          end else begin
            r = COLOR_BITS'(1);
            g = COLOR_BITS'(1);
            b = COLOR_BITS'(1);
          end
        end
        ModeGrey: begin
          r = i_pixel_x[GRAD_SHIFT+COLOR_BITS-1:GRAD_SHIFT];
          g = i_pixel_x[GRAD_SHIFT+COLOR_BITS-1:GRAD_SHIFT];
          b = i_pixel_x[GRAD_SHIFT+COLOR_BITS-1:GRAD_SHIFT];
        end
        ModeGrid: begin
          if ((i_pixel_x[CHECK_SHIFT-1:0] == '0) || (i_pixel_y[CHECK_SHIFT-1:0] == '0)) begin
            r = ChOn;
            g = ChOn;
            b = ChOn;
          end
        end
        ModeBorder: begin
          if ((x_wide == '0) || (x_wide == XCmpW'(H_ACTIVE - 1)) ||
              (y_wide == '0) || (y_wide == YCmpW'(V_ACTIVE - 1))) begin
            r = ChOn;
            g = ChOn;
            b = ChOn;
          end
        end
        ModeFlat: begin
          r = fc_r;
          g = fc_g;
          b = fc_b;
        end
      endcase
    end
    pix_d = {r, g, b};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q      <= ModeBars;
      frame_cnt_q <= '0;
      div_cnt_q   <= '0;
      sq_x_q      <= '0;
      sq_y_q      <= '0;
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
      pix_q       <= '0;
      de_q        <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      div_cnt_q   <= div_cnt_d;
      sq_x_q      <= sq_x_d;
      sq_y_q      <= sq_y_d;
      dir_x_neg_q <= dir_x_neg_d;
      dir_y_neg_q <= dir_y_neg_d;
      pix_q       <= pix_d;
      de_q        <= i_de;
    end
  end

  assign o_pixel_data = pix_q;
  assign o_de         = de_q;
  assign o_mode       = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed boundary cases plus random coordinates/modes
// compared every cycle against an arithmetic reference model.
module tb_vga_pattern_gen;

  localparam int H_ACT = 320;
  localparam int V_ACT = 240;
  localparam int SQ    = 32;
  localparam int STEP  = 1;
  localparam int FDIV  = 1;

  logic        i_clk;
  logic        i_rst;
  logic [8:0]  i_pixel_x;
  logic [8:0]  i_pixel_y;
  logic        i_de;
  logic        i_frame_start;
  logic [2:0]  i_mode;
  logic [11:0] o_pixel_data;
  logic        o_de;
  logic [2:0]  o_mode;

  int checks;
  int errors;

  // Reference model state.
  int m_mode, m_fc, m_div, m_sqx, m_sqy, m_dx, m_dy;

  vga_pattern_gen dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pixel_x    (i_pixel_x),
    .i_pixel_y    (i_pixel_y),
    .i_de         (i_de),
    .i_frame_start(i_frame_start),
    .i_mode       (i_mode),
    .o_pixel_data (o_pixel_data),
    .o_de         (o_de),
    .o_mode       (o_mode)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fc = 0; m_div = 0;
    m_sqx = 0; m_sqy = 0; m_dx = 1; m_dy = 1;
  endtask

  function automatic int bounce(input int pos, inout int dir, input int maxp);
    if (dir > 0) begin
      if (pos + STEP >= maxp) begin
        dir = -1;
        return maxp;
      end
      return pos + STEP;
    end
    if (pos <= STEP) begin
      dir = 1;
      return 0;
    end
    return pos - STEP;
  endfunction

  task automatic model_frame_start(input int mode);
    m_mode = mode;
    m_fc   = (m_fc + 1) % 256;
    m_div  = m_div + 1;
    if (m_div == FDIV) begin
      m_div = 0;
      m_sqx = bounce(m_sqx, m_dx, H_ACT - SQ);
      m_sqy = bounce(m_sqy, m_dy, V_ACT - SQ);
    end
  endtask

  function automatic logic [11:0] model_pixel(input int x, input int y, input bit de);
    int r, g, b, v;
    r = 0; g = 0; b = 0;
    if (!de || x >= H_ACT || y >= V_ACT) return 12'h000;
    case (m_mode)
      0: begin
        case (x * 8 / H_ACT)
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      1: return ((x / 16 + y / 16) % 2 == 1) ? 12'hFFF : 12'h000;
      2: begin r = (x / 16) % 16; g = (y / 16) % 16; b = 15; end
      3: begin
        if (x >= m_sqx && x < m_sqx + SQ && y >= m_sqy && y < m_sqy + SQ) return 12'hF00;
        return 12'h111;
      end
      4: begin v = (x / 16) % 16; r = v; g = v; b = v; end
      5: return (x % 16 == 0 || y % 16 == 0) ? 12'hFFF : 12'h000;
      6: return (x == 0 || x == H_ACT - 1 || y == 0 || y == V_ACT - 1) ? 12'hFFF : 12'h000;
      default: begin r = (m_fc / 32) * 2; g = ((m_fc / 4) % 8) * 2; b = (m_fc % 4) * 4; end
    endcase
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one coordinate, advance a cycle, compare registered outputs with the model.
  task automatic drive(input int x, input int y, input bit de, input bit fs, input int mode,
                       input string tag);
    logic [11:0] e_pix;
    i_pixel_x     = 9'(x);
    i_pixel_y     = 9'(y);
    i_de          = de;
    i_frame_start = fs;
    i_mode        = 3'(mode);
    e_pix = model_pixel(x, y, de);
    if (fs) model_frame_start(mode);
    step();
    i_frame_start = 1'b0;
    check_eq({tag, ".pix"}, 32'(o_pixel_data), 32'(e_pix));
    check_eq({tag, ".de"}, 32'(o_de), 32'(de));
    check_eq({tag, ".mode"}, 32'(o_mode), 32'(m_mode));
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    model_reset();
    repeat (2) step();
    i_rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_pixel_x = '0; i_pixel_y = '0; i_de = 1'b0; i_frame_start = 1'b0; i_mode = '0;
    i_rst = 1'b1;
    model_reset();
    repeat (3) step();
    check_eq("rst.pix", 32'(o_pixel_data), 32'h0);
    check_eq("rst.de", 32'(o_de), 32'h0);
    check_eq("rst.mode", 32'(o_mode), 32'h0);
    i_rst = 1'b0;

    // Latency, blanking, bars; mode request without frame start is ignored.
    drive(0, 0, 1, 0, 5, "lat");
    check_eq("lat0", 32'(o_pixel_data), 32'hFFF);
    drive(0, 0, 0, 0, 5, "blank");
    check_eq("blank0", 32'(o_pixel_data), 32'h0);
    drive(39, 0, 1, 0, 0, "bar39");
    check_eq("bar39c", 32'(o_pixel_data), 32'hFFF);
    drive(40, 0, 1, 0, 0, "bar40");
    check_eq("bar40c", 32'(o_pixel_data), 32'hFF0);
    drive(319, 0, 1, 0, 0, "bar319");
    check_eq("bar319c", 32'(o_pixel_data), 32'h000);
    drive(320, 5, 1, 0, 0, "oorx");
    check_eq("oorxc", 32'(o_pixel_data), 32'h000);
    drive(0, 240, 1, 0, 0, "oory");
    check_eq("ooryc", 32'(o_pixel_data), 32'h000);

    // Tearing: new mode only after frame start; the start cycle itself still uses the old mode.
    drive(40, 0, 1, 0, 1, "tear0");
    check_eq("tear0c", 32'(o_pixel_data), 32'hFF0);
    drive(40, 0, 1, 1, 1, "tear1");
    check_eq("tear1c", 32'(o_pixel_data), 32'hFF0);
    check_eq("tear1m", 32'(o_mode), 32'd1);
    drive(16, 0, 1, 0, 1, "chk16");
    check_eq("chk16c", 32'(o_pixel_data), 32'hFFF);
    drive(40, 0, 1, 0, 1, "chk40");
    check_eq("chk40c", 32'(o_pixel_data), 32'h000);

    // Y bounce edge.
    do_reset();
    for (int i = 0; i < 208; i++) drive(0, 0, 1, 1, 3, "ybnc");
    drive(208, 239, 1, 0, 3, "y208a");
    check_eq("y208ac", 32'(o_pixel_data), 32'hF00);
    drive(208, 207, 1, 0, 3, "y208b");
    check_eq("y208bc", 32'(o_pixel_data), 32'h111);
    drive(0, 0, 1, 1, 3, "ybnc");
    drive(209, 239, 1, 0, 3, "y207a");
    check_eq("y207ac", 32'(o_pixel_data), 32'h111);
    drive(209, 238, 1, 0, 3, "y207b");
    check_eq("y207bc", 32'(o_pixel_data), 32'hF00);

    // X bounce edge.
    do_reset();
    for (int i = 0; i < 288; i++) drive(0, 0, 1, 1, 3, "xbnc");
    drive(288, 128, 1, 0, 3, "x288a");
    check_eq("x288ac", 32'(o_pixel_data), 32'hF00);
    drive(287, 128, 1, 0, 3, "x288b");
    check_eq("x288bc", 32'(o_pixel_data), 32'h111);
    drive(319, 128, 1, 0, 3, "x288c");
    check_eq("x288cc", 32'(o_pixel_data), 32'hF00);
    drive(0, 0, 1, 1, 3, "xbnc");
    drive(287, 127, 1, 0, 3, "x287a");
    check_eq("x287ac", 32'(o_pixel_data), 32'hF00);
    drive(319, 127, 1, 0, 3, "x287b");
    check_eq("x287bc", 32'(o_pixel_data), 32'h111);

    // Frame counter wrap in flat-colour mode.
    do_reset();
    for (int i = 0; i < 255; i++) drive(0, 0, 0, 1, 7, "fcnt");
    drive(5, 5, 1, 0, 7, "fc255");
    check_eq("fc255c", 32'(o_pixel_data), 32'hEEC);
    drive(0, 0, 0, 1, 7, "fcnt");
    drive(5, 5, 1, 0, 7, "fc0");
    check_eq("fc0c", 32'(o_pixel_data), 32'h000);
    drive(0, 0, 0, 1, 7, "fcnt");
    drive(10, 10, 1, 0, 7, "fc1");
    check_eq("fc1c", 32'(o_pixel_data), 32'h004);

    // Asynchronous reset mid-line.
    i_de = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("arst.pix", 32'(o_pixel_data), 32'h0);
    check_eq("arst.de", 32'(o_de), 32'h0);
    check_eq("arst.mode", 32'(o_mode), 32'h0);
    model_reset();
    step();
    i_rst = 1'b0;
    drive(1, 1, 1, 1, 3, "post");
    check_eq("postc", 32'(o_pixel_data), 32'hFFF);
    drive(1, 1, 1, 0, 3, "sq11");
    check_eq("sq11c", 32'(o_pixel_data), 32'hF00);
    drive(0, 1, 1, 0, 3, "sq01");
    check_eq("sq01c", 32'(o_pixel_data), 32'h111);
    drive(32, 1, 1, 0, 3, "sq32");
    check_eq("sq32c", 32'(o_pixel_data), 32'hF00);
    drive(33, 1, 1, 0, 3, "sq33");
    check_eq("sq33c", 32'(o_pixel_data), 32'h111);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(int'($urandom_range(0, 350)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 7)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
